cube_timer_ctrl: RTL and testbench
==================================

# cube_timer_ctrl

Session controller for the virtual-cube solve timer. Sequences the 1 Hz `cube_timer` counter through idle, WCA-style inspection, timed solve and result hold by driving its reset and pause inputs. Applies +2/DNF penalties and keeps the last and best solve times in BCD for the display layer. Sits between the user button/cube-state logic and `cube_timer`.

## Interface
Parameters:
- INSP_SEC, 15, inspection length in seconds (1..99)
- PLUS2_SEC, 2, overtime window before DNF (1..9)

Ports:
- clk_1Hz  in  1  1 Hz system tick; all state changes on its rising edge
- I_reset  in  1  asynchronous, active-high; clears all state
- I_start  in  1  start/stop button level; upstream-debounced; acts on its rising edge
- I_move  in  1  high while a cube move is pending; held ≥1 tick by upstream
- I_solved  in  1  cube-solved flag, level
- I_time  in  12  timer count in BCD {m0, s1, s0}, as held by cube_timer
- O_timer_reset  out  1  drives cube_timer I_reset
- O_timer_pause  out  1  drives cube_timer I_pause
- O_state  out  3  FSM state code
- O_insp  out  8  remaining inspection, two BCD digits
- O_plus2  out  1  +2 penalty applied to current solve
- O_dnf  out  1  current solve is DNF
- O_last_time  out  12  captured, penalty-adjusted time of last solve, BCD
- O_best_time  out  12  best non-DNF time, BCD
- O_best_valid  out  1  O_best_time holds a real result
- O_new_best  out  1  one-tick pulse when best is updated

## Operation
- Internal start_prev register; start_rise = I_start & ~start_prev.
- States: IDLE=0, INSPECT=1, OVERTIME=2, RUNNING=3, DONE=4.
- IDLE: timer reset=1, pause=1. On start_rise → INSPECT, O_insp←INSP_SEC (BCD), plus2/dnf cleared.
- INSPECT: reset=1, pause=1. I_move → RUNNING. Otherwise O_insp decrements each tick. At O_insp==0 with no move → OVERTIME, ot_cnt←PLUS2_SEC.
- OVERTIME: reset=1, pause=1. I_move → RUNNING, O_plus2←1. Otherwise ot_cnt decrements. At ot_cnt==0 → DONE, O_dnf←1.
- RUNNING: reset=0, pause=0. Leaves for DONE on I_solved or on start_rise (manual stop). Also leaves on I_time==9:59 (12'h959), with O_dnf←1. Priority order: I_solved, then 9:59, then start_rise.
- DONE: reset=0, pause=1; display frozen. First tick in DONE: capture I_time. If O_plus2, add PLUS2_SEC in BCD with carry s0→s1→m0, saturating at 9:59. Write the result to O_last_time. If !O_dnf and (!O_best_valid or last<best): update best, set O_best_valid=1, pulse O_new_best for one tick. BCD compare is lexicographic m0, s1, s0. Later start_rise → IDLE.
- I_move in IDLE/DONE and I_solved outside RUNNING are ignored. start_rise in INSPECT/OVERTIME is ignored.
- Best survives IDLE; only I_reset clears it.

## Timing
- All outputs are registered; no combinational input→output path.
- Reset values: state IDLE, O_timer_reset=1, O_timer_pause=1, O_insp=8'h00, O_plus2=0, O_dnf=0, O_last_time=0, O_best_time=12'h959, O_best_valid=0, O_new_best=0, start_prev=0.
- RUNNING is entered at edge k. Reset and pause fall after k, and the timer first increments at edge k+1.
- DONE is entered at edge n. The timer still increments at n, because pause rises after n. The capture happens at n+1 on the frozen value. O_last_time and O_new_best are valid after n+1.
- Inspection: a move is never sampled earlier than 1 tick after start_rise. With no move, OVERTIME is entered INSP_SEC ticks after INSPECT entry, and DONE/DNF follows PLUS2_SEC ticks later.
- I_reset mid-solve: immediate return to reset values, including the timer reset output, which asserts asynchronously.

## Configuration
- CUBE_CTRL_INSPECTION_EN defined: behaviour as above.
- Not defined: INSPECT and OVERTIME are removed. start_rise in IDLE → RUNNING directly. O_insp is tied to 0 and O_plus2 is never set.

## Structure
- Shared package cube_timer_pkg holds:
  - state encoding constants
  - BCD time width (12) and the digit-slice constants
  - the 9:59 saturation constant
  - INSP_SEC/PLUS2_SEC defaults
- One sub-module, cube_bcd_addcmp: combinational BCD saturating add of a 4-bit seconds value, plus a less-than compare. Used for the penalty and best-time update.

## Test plan
- Start, move at inspection tick 3, solved with I_time=0:42 → RUNNING entered, DONE reached, O_last_time=12'h042, O_best_time=12'h042, O_new_best pulses once.
- No move for 15 ticks, move during overtime, solved at 0:58 → O_plus2=1, O_last_time=12'h100.
- No move for 15+2 ticks → DONE with O_dnf=1; best unchanged, O_best_valid stays 0.
- Two solves of 0:30 then 0:45 → best stays 12'h030; O_new_best only on the first.
- Run until I_time=12'h959 → DONE, O_dnf=1, pause high the following tick.
- I_reset asserted mid-RUNNING with a best stored → all outputs at reset values, O_best_valid=0; with the macro undefined, start goes IDLE→RUNNING in one tick.

Source files
------------

// File: rtl/cube_timer_pkg.sv
// Shared types and constants for the cube solve-timer session controller.
// Inspection support is compiled in only when CUBE_CTRL_INSPECTION_EN is defined.
package cube_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INSPECT  = 3'd1,
        ST_OVERTIME = 3'd2,
        ST_RUNNING  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Times are BCD {m0, s1, s0}
    localparam int TIME_W  = 12;
    localparam int DIGIT_W = 4;
    localparam int S0_LSB  = 0;
    localparam int S1_LSB  = 4;
    localparam int M0_LSB  = 8;

    localparam logic [TIME_W-1:0] TIME_MAX = 12'h959;

    localparam int INSP_SEC_DEF  = 15;
    localparam int PLUS2_SEC_DEF = 2;

    function automatic logic [7:0] to_bcd8(input int value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 10);
        ones = 4'(value % 10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] bcd_dec8(input logic [7:0] value);
        if (value == 8'h00) begin
            return 8'h00;
        end
        if (value[3:0] == 4'h0) begin
            return {value[7:4] - 4'd1, 4'h9};
        end
        return {value[7:4], value[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/cube_timer_ctrl_addcmp.sv
// Combinational BCD time adder (saturating at 9:59) and less-than compare
// of the sum against a reference time.
module cube_bcd_addcmp
    import cube_timer_pkg::*;
(
    input  logic [TIME_W-1:0]  time_i,
    input  logic [DIGIT_W-1:0] add_i,
    input  logic [TIME_W-1:0]  ref_i,
    output logic [TIME_W-1:0]  sum_o,
    output logic               lt_o
);

    logic [DIGIT_W:0]   s0Sum;
    logic [DIGIT_W:0]   s1Sum;
    logic [DIGIT_W:0]   m0Sum;
    logic [DIGIT_W-1:0] s0Digit;
    logic [DIGIT_W-1:0] s1Digit;
    logic               s0Carry;
    logic               s1Carry;

    // Seconds-units wrap at 10, seconds-tens at 6; minutes overflow saturates.
    always_comb begin
        s0Sum   = {1'b0, time_i[S0_LSB +: DIGIT_W]} + {1'b0, add_i};
        s0Carry = (s0Sum > 5'd9);
        s0Digit = s0Carry ? 4'(s0Sum - 5'd10) : s0Sum[DIGIT_W-1:0];

        s1Sum   = {1'b0, time_i[S1_LSB +: DIGIT_W]} + {4'd0, s0Carry};
        s1Carry = (s1Sum > 5'd5);
        s1Digit = s1Carry ? 4'(s1Sum - 5'd6) : s1Sum[DIGIT_W-1:0];

        m0Sum   = {1'b0, time_i[M0_LSB +: DIGIT_W]} + {4'd0, s1Carry};

        if (m0Sum > 5'd9) begin
            sum_o = TIME_MAX;
        end else begin
            sum_o = {m0Sum[DIGIT_W-1:0], s1Digit, s0Digit};
        end

        // Valid BCD orders the same as plain binary, digit by digit.
        lt_o = (sum_o < ref_i);
    end

endmodule

// File: rtl/cube_timer_ctrl.sv
// Session controller for the 1 Hz cube timer: idle, optional WCA inspection
// (CUBE_CTRL_INSPECTION_EN), timed solve and result hold with +2/DNF and best time.
module cube_timer_ctrl
    import cube_timer_pkg::*;
#(
    parameter int INSP_SEC  = INSP_SEC_DEF,
    parameter int PLUS2_SEC = PLUS2_SEC_DEF
) (
    input  logic              clk_1Hz,
    input  logic              I_reset,
    input  logic              I_start,
    input  logic              I_move,
    input  logic              I_solved,
    input  logic [TIME_W-1:0] I_time,
    output logic              O_timer_reset,
    output logic              O_timer_pause,
    output logic [2:0]        O_state,
    output logic [7:0]        O_insp,
    output logic              O_plus2,
    output logic              O_dnf,
    output logic [TIME_W-1:0] O_last_time,
    output logic [TIME_W-1:0] O_best_time,
    output logic              O_best_valid,
    output logic              O_new_best
);

    localparam logic [DIGIT_W-1:0] PLUS2_BCD = 4'(PLUS2_SEC);

    state_t            state_q;
    logic              startPrev_q;
    logic              timerReset_q;
    logic              timerPause_q;
    logic              plus2_q;
    logic              dnf_q;
    logic              capture_q;
    logic [TIME_W-1:0] lastTime_q;
    logic [TIME_W-1:0] bestTime_q;
    logic              bestValid_q;
    logic              newBest_q;

    logic              startRise_d;
    logic [TIME_W-1:0] adjTime_d;
    logic              adjLess_d;

`ifdef CUBE_CTRL_INSPECTION_EN
    localparam logic [7:0] INSP_BCD = to_bcd8(INSP_SEC);

    logic [7:0]         inspCnt_q;
    logic [DIGIT_W-1:0] otCnt_q;
`else
    logic unusedInputs;
    assign unusedInputs = I_move ^ (INSP_SEC != 0);
`endif

    assign startRise_d = I_start & ~startPrev_q;

    cube_bcd_addcmp u_addcmp (
        .time_i (I_time),
        .add_i  (plus2_q ? PLUS2_BCD : 4'd0),
        .ref_i  (bestTime_q),
        .sum_o  (adjTime_d),
        .lt_o   (adjLess_d)
    );

    // Timer reset/pause are registered alongside each state change so the
    // timer starts one tick after RUNNING entry and still counts on DONE entry.
    always_ff @(posedge clk_1Hz or posedge I_reset) begin
        if (I_reset) begin
            state_q      <= ST_IDLE;
            startPrev_q  <= 1'b0;
            timerReset_q <= 1'b1;
            timerPause_q <= 1'b1;
            plus2_q      <= 1'b0;
            dnf_q        <= 1'b0;
            capture_q    <= 1'b0;
            lastTime_q   <= '0;
            bestTime_q   <= TIME_MAX;
            bestValid_q  <= 1'b0;
            newBest_q    <= 1'b0;
`ifdef CUBE_CTRL_INSPECTION_EN
            inspCnt_q    <= 8'h00;
            otCnt_q      <= '0;
`endif
        end else begin
            startPrev_q <= I_start;
            newBest_q   <= 1'b0;
            capture_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (startRise_d) begin
                        plus2_q <= 1'b0;
                        dnf_q   <= 1'b0;
`ifdef CUBE_CTRL_INSPECTION_EN
                        state_q   <= ST_INSPECT;
                        inspCnt_q <= INSP_BCD;
`else
                        state_q      <= ST_RUNNING;
                        timerReset_q <= 1'b0;
                        timerPause_q <= 1'b0;
`endif
                    end
                end

`ifdef CUBE_CTRL_INSPECTION_EN
                ST_INSPECT: begin
                    if (I_move) begin
                        state_q      <= ST_RUNNING;
                        timerReset_q <= 1'b0;
                        timerPause_q <= 1'b0;
                    end else begin
                        inspCnt_q <= bcd_dec8(inspCnt_q);
                        if (inspCnt_q <= 8'h01) begin
                            state_q <= ST_OVERTIME;
                            otCnt_q <= PLUS2_BCD;
                        end
                    end
                end

                ST_OVERTIME: begin
                    if (I_move) begin
                        state_q      <= ST_RUNNING;
                        plus2_q      <= 1'b1;
                        timerReset_q <= 1'b0;
                        timerPause_q <= 1'b0;
                    end else if (otCnt_q <= 4'd1) begin
                        state_q      <= ST_DONE;
                        dnf_q        <= 1'b1;
                        otCnt_q      <= '0;
                        timerReset_q <= 1'b0;
                        timerPause_q <= 1'b1;
                        capture_q    <= 1'b1;
                    end else begin
                        otCnt_q <= otCnt_q - 4'd1;
                    end
                end
`endif

                ST_RUNNING: begin
                    if (I_solved || (I_time == TIME_MAX) || startRise_d) begin
                        state_q      <= ST_DONE;
                        timerPause_q <= 1'b1;
                        capture_q    <= 1'b1;
                        dnf_q        <= ~I_solved && (I_time == TIME_MAX);
                    end
                end

                ST_DONE: begin
                    if (capture_q) begin
                        lastTime_q <= adjTime_d;
                        if (!dnf_q && (!bestValid_q || adjLess_d)) begin
                            bestTime_q  <= adjTime_d;
                            bestValid_q <= 1'b1;
                            newBest_q   <= 1'b1;
                        end
                    end
                    if (startRise_d) begin
                        state_q      <= ST_IDLE;
                        timerReset_q <= 1'b1;
                        timerPause_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_timer_reset = timerReset_q;
    assign O_timer_pause = timerPause_q;
    assign O_state       = state_q;
    assign O_plus2       = plus2_q;
    assign O_dnf         = dnf_q;
    assign O_last_time   = lastTime_q;
    assign O_best_time   = bestTime_q;
    assign O_best_valid  = bestValid_q;
    assign O_new_best    = newBest_q;
`ifdef CUBE_CTRL_INSPECTION_EN
    assign O_insp        = inspCnt_q;
`else
    assign O_insp        = 8'h00;
`endif

endmodule

// File: tb/tb_cube_timer_ctrl.sv
// Directed table-driven bench for cube_timer_ctrl; the vector table follows
// the CUBE_CTRL_INSPECTION_EN build setting.
module tb_cube_timer_ctrl;

    localparam int INSP  = 15;
    localparam int PLUS2 = 2;

    logic        clk_1Hz = 1'b0;
    logic        I_reset;
    logic        I_start;
    logic        I_move;
    logic        I_solved;
    logic [11:0] I_time;
    logic        O_timer_reset;
    logic        O_timer_pause;
    logic [2:0]  O_state;
    logic [7:0]  O_insp;
    logic        O_plus2;
    logic        O_dnf;
    logic [11:0] O_last_time;
    logic [11:0] O_best_time;
    logic        O_best_valid;
    logic        O_new_best;

    typedef struct packed {
        logic [2:0]  st;
        logic        rst;
        logic        pse;
        logic [7:0]  insp;
        logic        plus2;
        logic        dnf;
        logic [11:0] last;
        logic [11:0] best;
        logic        valid;
        logic        newBest;
    } expect_t;

    typedef struct packed {
        logic        start;
        logic        move;
        logic        solved;
        logic [11:0] tm;
        expect_t     ex;
    } vec_t;

    vec_t    vecs[$];
    expect_t ex;
    expect_t resetEx;
    int      checks   = 0;
    int      failures = 0;
    int      vecIdx   = -1;

    cube_timer_ctrl #(.INSP_SEC(INSP), .PLUS2_SEC(PLUS2)) dut (
        .clk_1Hz       (clk_1Hz),
        .I_reset       (I_reset),
        .I_start       (I_start),
        .I_move        (I_move),
        .I_solved      (I_solved),
        .I_time        (I_time),
        .O_timer_reset (O_timer_reset),
        .O_timer_pause (O_timer_pause),
        .O_state       (O_state),
        .O_insp        (O_insp),
        .O_plus2       (O_plus2),
        .O_dnf         (O_dnf),
        .O_last_time   (O_last_time),
        .O_best_time   (O_best_time),
        .O_best_valid  (O_best_valid),
        .O_new_best    (O_new_best)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic addVec(input logic start, input logic move, input logic solved,
                          input logic [11:0] tm);
        vec_t v;
        v.start  = start;
        v.move   = move;
        v.solved = solved;
        v.tm     = tm;
        v.ex     = ex;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic start, input logic move, input logic solved,
                                 input logic [11:0] tm);
        I_start  = start;
        I_move   = move;
        I_solved = solved;
        I_time   = tm;
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at vector %0d: got %h, want %h", name, vecIdx, act, exp);
        end
    endtask

    task automatic checkAll(input expect_t e);
        checkOutput("state",      12'(O_state),       12'(e.st));
        checkOutput("timerReset", 12'(O_timer_reset), 12'(e.rst));
        checkOutput("timerPause", 12'(O_timer_pause), 12'(e.pse));
        checkOutput("insp",       12'(O_insp),        12'(e.insp));
        checkOutput("plus2",      12'(O_plus2),       12'(e.plus2));
        checkOutput("dnf",        12'(O_dnf),         12'(e.dnf));
        checkOutput("lastTime",   O_last_time,        e.last);
        checkOutput("bestTime",   O_best_time,        e.best);
        checkOutput("bestValid",  12'(O_best_valid),  12'(e.valid));
        checkOutput("newBest",    12'(O_new_best),    12'(e.newBest));
    endtask

    // Helpers that move the running expectation between common states.
    task automatic expIdle();
        ex.st = 3'd0; ex.rst = 1'b1; ex.pse = 1'b1; ex.newBest = 1'b0;
    endtask

    task automatic expRunning();
        ex.st = 3'd3; ex.rst = 1'b0; ex.pse = 1'b0; ex.newBest = 1'b0;
    endtask

    task automatic expDone();
        ex.st = 3'd4; ex.rst = 1'b0; ex.pse = 1'b1; ex.newBest = 1'b0;
    endtask

    task automatic buildTable();
`ifdef CUBE_CTRL_INSPECTION_EN
        // DNF: no move through inspection and overtime
        ex.st = 3'd1; ex.insp = bcd(INSP); ex.dnf = 1'b0; ex.plus2 = 1'b0;
        addVec(1, 0, 0, 12'h000);
        for (int i = 1; i < INSP; i++) begin
            ex.insp = bcd(INSP - i);
            addVec(0, 0, 0, 12'h000);
        end
        ex.st = 3'd2; ex.insp = 8'h00;
        addVec(0, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);
        expDone(); ex.dnf = 1'b1;
        addVec(0, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);
        expIdle();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);

        // Move at inspection tick 3, solved at 0:42
        ex.st = 3'd1; ex.insp = bcd(INSP); ex.dnf = 1'b0;
        addVec(1, 0, 0, 12'h000);
        ex.insp = bcd(INSP - 1); addVec(0, 0, 0, 12'h000);
        ex.insp = bcd(INSP - 2); addVec(0, 0, 0, 12'h000);
        expRunning();
        addVec(0, 1, 0, 12'h000);
        addVec(0, 0, 0, 12'h041);
        expDone();
        addVec(0, 0, 1, 12'h042);
        ex.last = 12'h042; ex.best = 12'h042; ex.valid = 1'b1; ex.newBest = 1'b1;
        addVec(0, 0, 1, 12'h042);
        ex.newBest = 1'b0;
        addVec(0, 0, 0, 12'h042);
        expIdle();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);

        // Move in overtime, solved at 0:58 -> +2 gives 1:00
        ex.st = 3'd1; ex.insp = bcd(INSP);
        addVec(1, 0, 0, 12'h000);
        for (int i = 1; i < INSP; i++) begin
            ex.insp = bcd(INSP - i);
            addVec(0, 0, 0, 12'h000);
        end
        ex.st = 3'd2; ex.insp = 8'h00;
        addVec(0, 0, 0, 12'h000);
        expRunning(); ex.plus2 = 1'b1;
        addVec(0, 1, 0, 12'h000);
        expDone();
        addVec(0, 0, 1, 12'h058);
        ex.last = 12'h100;
        addVec(0, 0, 1, 12'h058);
        expIdle();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);

        // Move on the last overtime tick, solved at 9:58 -> +2 saturates to 9:59
        ex.st = 3'd1; ex.insp = bcd(INSP); ex.plus2 = 1'b0;
        addVec(1, 0, 0, 12'h000);
        for (int i = 1; i < INSP; i++) begin
            ex.insp = bcd(INSP - i);
            addVec(0, 0, 0, 12'h000);
        end
        ex.st = 3'd2; ex.insp = 8'h00;
        addVec(0, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);
        expRunning(); ex.plus2 = 1'b1;
        addVec(0, 1, 0, 12'h000);
        expDone();
        addVec(0, 0, 1, 12'h958);
        ex.last = 12'h959;
        addVec(0, 0, 1, 12'h958);
        expIdle();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);
`else
        // Solve at 0:42 becomes first best
        expRunning();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h041);
        expDone();
        addVec(0, 0, 1, 12'h042);
        ex.last = 12'h042; ex.best = 12'h042; ex.valid = 1'b1; ex.newBest = 1'b1;
        addVec(0, 0, 1, 12'h042);
        ex.newBest = 1'b0;
        addVec(0, 0, 0, 12'h042);
        expIdle();
        addVec(1, 0, 0, 12'h042);
        addVec(0, 0, 0, 12'h000);

        // Slower 0:45 leaves best alone
        expRunning();
        addVec(1, 0, 0, 12'h000);
        expDone();
        addVec(0, 0, 1, 12'h045);
        ex.last = 12'h045;
        addVec(0, 0, 0, 12'h045);
        expIdle();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);

        // Manual stop at 0:30 is a new best; held start is not a second rise
        expRunning();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h029);
        expDone();
        addVec(1, 0, 0, 12'h030);
        ex.last = 12'h030; ex.best = 12'h030; ex.newBest = 1'b1;
        addVec(1, 0, 0, 12'h030);
        ex.newBest = 1'b0;
        addVec(0, 0, 0, 12'h030);
        expIdle();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);

        // Timer reaching 9:59 forces DNF
        expRunning();
        addVec(1, 0, 0, 12'h000);
        expDone(); ex.dnf = 1'b1;
        addVec(0, 0, 0, 12'h959);
        ex.last = 12'h959;
        addVec(0, 0, 0, 12'h959);
        expIdle();
        addVec(1, 0, 0, 12'h000);
        addVec(0, 0, 0, 12'h000);

        // Solved wins over 9:59; the result is not better than 0:30
        expRunning(); ex.dnf = 1'b0;
        addVec(1, 0, 0, 12'h000);
        expDone();
        addVec(0, 0, 1, 12'h959);
        addVec(0, 0, 1, 12'h959);
        expIdle();
        addVec(1, 1, 0, 12'h000);
        addVec(0, 1, 1, 12'h000);
`endif
    endtask

    initial begin
        I_reset  = 1'b1;
        I_start  = 1'b0;
        I_move   = 1'b0;
        I_solved = 1'b0;
        I_time   = 12'h000;

        resetEx = '{st: 3'd0, rst: 1'b1, pse: 1'b1, insp: 8'h00, plus2: 1'b0, dnf: 1'b0,
                    last: 12'h000, best: 12'h959, valid: 1'b0, newBest: 1'b0};
        ex = resetEx;

        repeat (2) @(posedge clk_1Hz);
        #1;
        checkAll(resetEx);
        I_reset = 1'b0;

        buildTable();
        for (int i = 0; i < vecs.size(); i++) begin
            vecIdx = i;
            applyStimulus(vecs[i].start, vecs[i].move, vecs[i].solved, vecs[i].tm);
            checkAll(vecs[i].ex);
        end

        // Asynchronous reset in the middle of a running solve with a best stored
        vecIdx = -2;
        checkOutput("bestValidBeforeReset", 12'(O_best_valid), 12'h001);
`ifdef CUBE_CTRL_INSPECTION_EN
        applyStimulus(1, 0, 0, 12'h000);
        checkOutput("inspectEntry", 12'(O_state), 12'd1);
        applyStimulus(0, 1, 0, 12'h000);
`else
        applyStimulus(1, 0, 0, 12'h000);
`endif
        checkOutput("runningEntry", 12'(O_state), 12'd3);
        applyStimulus(0, 0, 0, 12'h007);
        checkOutput("stillRunning", 12'(O_state), 12'd3);
        #2;
        I_reset = 1'b1;
        #1;
        checkAll(resetEx);
        #1;
        I_reset = 1'b0;
        applyStimulus(0, 0, 0, 12'h000);
        checkAll(resetEx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
